// File: rtl/systolic_array_controller_if.sv
// Command and array-control bundle for the systolic array sequencer.
// The master side issues jobs; the slave side (the controller) drives the array and buffers.
interface systolic_array_controller_if #(
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 8
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                  start;
    logic [ADDR_WIDTH:0]   num_vectors;
    logic                  busy;
    logic                  done;
    logic                  pe_clr;
    logic                  pe_en;
    logic                  pe_load;
    logic                  act_zero;
    logic                  w_rd_en;
    logic [CW-1:0]         w_rd_addr;
    logic                  a_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic                  out_wr_en;
    logic [ADDR_WIDTH-1:0] out_wr_addr;

    modport master (
        output start, num_vectors,
        input  busy, done, pe_clr, pe_en, pe_load, act_zero,
        input  w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, out_wr_en, out_wr_addr
    );

    modport slave (
        input  start, num_vectors,
        output busy, done, pe_clr, pe_en, pe_load, act_zero,
        output w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, out_wr_en, out_wr_addr
    );
endinterface

// File: rtl/systolic_array_controller.sv
// Job sequencer for a weight-stationary ROWS x COLS array: clear, load weights,
// stream activations, drain, and write results, with every output registered.
module systolic_array_controller #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 8
) (
    input logic                      clk,
    input logic                      sync_rst,
    systolic_array_controller_if.slave bus
);
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_N      = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W-1:0]        n_lat, n_nxt;
    logic [ROWS:0]           wr_pipe;

    logic                    busy_r, done_r, pe_clr_r, pe_en_r, pe_load_r, act_zero_r;
    logic                    w_rd_en_r, a_rd_en_r;
    logic [CW-1:0]           w_rd_addr_r;
    logic [ADDR_WIDTH-1:0]   a_rd_addr_r, out_wr_addr_r;

    always_comb begin
        state_nxt = state;
        n_nxt     = n_lat;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                    n_nxt     = (bus.num_vectors > MAX_N) ? MAX_N : bus.num_vectors;
                end
            end
            S_CLEAR:   state_nxt = S_LOAD;
            S_LOAD: begin
                if (cnt == LOAD_LAST)
                    state_nxt = (n_lat == '0) ? S_DONE : S_COMPUTE;
            end
            S_COMPUTE: begin
                if (cnt == n_lat - CNT_W'(1))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                n_nxt     = '0;
            end
            default:   state_nxt = S_IDLE;
        endcase

        // cnt is the cycle index within the current state; it restarts on every transition
        if (state_nxt != state || state_nxt == S_IDLE)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            n_lat         <= '0;
            wr_pipe       <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pe_clr_r      <= 1'b0;
            pe_en_r       <= 1'b0;
            pe_load_r     <= 1'b0;
            act_zero_r    <= 1'b0;
            w_rd_en_r     <= 1'b0;
            w_rd_addr_r   <= '0;
            a_rd_en_r     <= 1'b0;
            a_rd_addr_r   <= '0;
            out_wr_addr_r <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            n_lat       <= n_nxt;
            busy_r      <= (state_nxt != S_IDLE);
            done_r      <= (state_nxt == S_DONE);
            pe_clr_r    <= (state_nxt == S_CLEAR);
            w_rd_en_r   <= (state_nxt == S_LOAD);
            w_rd_addr_r <= (state_nxt == S_LOAD) ? cnt_nxt[CW-1:0] : '0;
            a_rd_en_r   <= (state_nxt == S_COMPUTE);
            a_rd_addr_r <= (state_nxt == S_COMPUTE) ? cnt_nxt[ADDR_WIDTH-1:0] : '0;
            // Array controls lag the read strobes by the one-cycle buffer latency
            pe_en_r     <= (state inside {S_LOAD, S_COMPUTE, S_DRAIN});
            pe_load_r   <= (state == S_LOAD);
            act_zero_r  <= (state == S_DRAIN);
            // A vector read now leaves the bottom PE row ROWS+1 cycles later
            wr_pipe     <= {wr_pipe[ROWS-1:0], a_rd_en_r};
            if (state_nxt == S_IDLE)
                out_wr_addr_r <= '0;
            else if (wr_pipe[ROWS] && wr_pipe[ROWS-1])
                out_wr_addr_r <= out_wr_addr_r + ADDR_WIDTH'(1);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pe_clr      = pe_clr_r;
    assign bus.pe_en       = pe_en_r;
    assign bus.pe_load     = pe_load_r;
    assign bus.act_zero    = act_zero_r;
    assign bus.w_rd_en     = w_rd_en_r;
    assign bus.w_rd_addr   = w_rd_addr_r;
    assign bus.a_rd_en     = a_rd_en_r;
    assign bus.a_rd_addr   = a_rd_addr_r;
    assign bus.out_wr_en   = wr_pipe[ROWS];
    assign bus.out_wr_addr = out_wr_addr_r;
endmodule

// File: tb/tb_systolic_array_controller.sv
// Scoreboard bench for the systolic array sequencer: each job's expected output
// events are queued at launch and matched against the DUT on every falling edge.
module tb_systolic_array_controller;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int AW   = 8;

    logic clk = 1'b0;
    logic sync_rst = 1'b1;
    always #5 clk = ~clk;

    systolic_array_controller_if #(.COLS(COLS), .ADDR_WIDTH(AW)) bus ();

    systolic_array_controller #(.ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    // kinds: 0 pe_clr, 1 pe_en, 2 pe_load, 3 act_zero, 4 w_rd, 5 a_rd, 6 out_wr, 7 busy, 8 done
    typedef struct {
        int kind;
        int cyc;
        int addr;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int k, input int c, input int a);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        sb.push_back(e);
    endfunction

    // Expected event cycles relative to the START cycle (base), from the job timeline
    function automatic void push_job(input int base, input int nraw);
        int n;
        int d;
        n = (nraw > (1 << AW)) ? (1 << AW) : nraw;
        d = (n == 0) ? COLS + 2 : 2 * COLS + ROWS + n + 1;
        push(0, base + 1, 0);
        for (int i = 1; i <= d; i++) push(7, base + i, 0);
        push(8, base + d, 0);
        for (int i = 0; i < COLS; i++) begin
            push(4, base + 2 + i, i);
            push(2, base + 3 + i, 0);
        end
        for (int i = base + 3; i <= base + d; i++) push(1, i, 0);
        for (int k = 0; k < n; k++) begin
            push(5, base + COLS + 2 + k, k);
            push(6, base + COLS + ROWS + 3 + k, k);
        end
        if (n > 0)
            for (int i = base + COLS + 3 + n; i <= base + d; i++) push(3, i, 0);
    endfunction

    task automatic see(input int k, input string tag, input logic v, input int addr);
        int  idx;
        ev_t e;
        idx = -1;
        if (v !== 1'b0) begin
            foreach (sb[i]) if (idx < 0 && sb[i].kind == k) idx = i;
            e.kind = k;
            e.cyc  = -1;
            e.addr = -1;
            if (idx >= 0) begin
                e = sb[idx];
                sb.delete(idx);
            end
            total++;
            assert ((e.cyc === cyc) && (e.addr === addr)) else begin
                bad++;
                $error("FAIL %s: observed cyc=%0d addr=%0d, expected cyc=%0d addr=%0d",
                       tag, cyc, addr, e.cyc, e.addr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            see(0, "pe_clr",   bus.pe_clr,    0);
            see(1, "pe_en",    bus.pe_en,     0);
            see(2, "pe_load",  bus.pe_load,   0);
            see(3, "act_zero", bus.act_zero,  0);
            see(4, "w_rd",     bus.w_rd_en,   int'(bus.w_rd_addr));
            see(5, "a_rd",     bus.a_rd_en,   int'(bus.a_rd_addr));
            see(6, "out_wr",   bus.out_wr_en, int'(bus.out_wr_addr));
            see(7, "busy",     bus.busy,      0);
            see(8, "done",     bus.done,      0);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk_eq({tag, " busy"},        32'(bus.busy),        32'd0);
        chk_eq({tag, " done"},        32'(bus.done),        32'd0);
        chk_eq({tag, " pe_clr"},      32'(bus.pe_clr),      32'd0);
        chk_eq({tag, " pe_en"},       32'(bus.pe_en),       32'd0);
        chk_eq({tag, " pe_load"},     32'(bus.pe_load),     32'd0);
        chk_eq({tag, " act_zero"},    32'(bus.act_zero),    32'd0);
        chk_eq({tag, " w_rd_en"},     32'(bus.w_rd_en),     32'd0);
        chk_eq({tag, " w_rd_addr"},   32'(bus.w_rd_addr),   32'd0);
        chk_eq({tag, " a_rd_en"},     32'(bus.a_rd_en),     32'd0);
        chk_eq({tag, " a_rd_addr"},   32'(bus.a_rd_addr),   32'd0);
        chk_eq({tag, " out_wr_en"},   32'(bus.out_wr_en),   32'd0);
        chk_eq({tag, " out_wr_addr"}, 32'(bus.out_wr_addr), 32'd0);
    endtask

    task automatic drained(input string tag);
        total++;
        assert (sb.size() === 0) else begin
            bad++;
            $error("FAIL %s: observed %0d unmatched expected events, expected 0 (first kind=%0d cyc=%0d)",
                   tag, sb.size(), sb[0].kind, sb[0].cyc);
        end
        sb.delete();
    endtask

    function automatic void prune(input int lim);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc >= lim) sb.delete(i);
    endfunction

    // Called at a falling edge; returns one cycle after the START cycle
    task automatic go(input int n, output int base);
        base = cyc;
        push_job(base, n);
        bus.start       = 1'b1;
        bus.num_vectors = (AW + 1)'(n);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int b;
        bus.start       = 1'b0;
        bus.num_vectors = '0;
        sync_rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        sync_rst = 1'b0;
        mon_on   = 1'b1;
        @(negedge clk);

        // Plain N=3 job
        go(3, b);
        repeat (20) @(negedge clk);
        drained("job n3");
        chk_eq("idle after n3", 32'(bus.busy), 32'd0);

        // N=0: load then straight to done
        go(0, b);
        repeat (10) @(negedge clk);
        drained("job n0");

        // Stray STARTs during COMPUTE and at DONE, then a back-to-back job
        go(3, b);
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        bus.num_vectors = 9'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.num_vectors = 9'd5;
        @(negedge clk);
        go(2, b);
        repeat (20) @(negedge clk);
        drained("stray start + back-to-back");

        // Reset mid-job at cycle 7: nothing further, then a normal job
        go(3, b);
        repeat (6) @(negedge clk);
        prune(b + 8);
        sync_rst = 1'b1;
        @(negedge clk);
        sync_rst = 1'b0;
        check_idle("abort");
        repeat (20) @(negedge clk);
        drained("abort");
        go(1, b);
        repeat (20) @(negedge clk);
        drained("job after abort");

        // Oversized count saturates to 2^AW vectors
        go(300, b);
        repeat (2 * COLS + ROWS + (1 << AW) + 6) @(negedge clk);
        drained("saturate n300");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_array_controller.md
# systolic_array_controller

Sequencer for the weight-stationary ROWS x COLS array of processing elements. On a START handshake it clears the array, streams one weight row per column position through the horizontal shift path in LOAD mode, streams NUM_VECTORS activation vectors in compute mode, drains the pipeline with zero activations, and writes results to the output buffer before pulsing DONE. The block sits between the top-level command interface and the array plus its weight, activation and output buffers. Row/column skew registers are external; this block only issues addresses and array control.

## Interface
- ROWS, 8, number of PE rows (psum flows down ROWS rows)
- COLS, 8, number of PE columns (inputs/weights shift right across COLS PEs)
- ADDR_WIDTH, 8, buffer address width; max NUM_VECTORS = 2^ADDR_WIDTH

Ports:
- CLK  input  1  system clock, all logic on rising edge
- SYNC_RST  input  1  reset, synchronous, active-high
- START  input  1  one-cycle request, sampled only in IDLE
- NUM_VECTORS  input  ADDR_WIDTH+1  activation vector count, latched on accepted START
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle completion pulse
- PE_CLR  output  1  drives the array SYNC_RST
- PE_EN  output  1  drives array EN
- PE_LOAD  output  1  drives array LOAD
- ACT_ZERO  output  1  forces the array row inputs to 0 (drain)
- W_RD_EN  output  1  weight buffer read strobe
- W_RD_ADDR  output  clog2(COLS)  weight buffer address
- A_RD_EN  output  1  activation buffer read strobe
- A_RD_ADDR  output  ADDR_WIDTH  activation buffer address
- OUT_WR_EN  output  1  output buffer write strobe
- OUT_WR_ADDR  output  ADDR_WIDTH  output buffer address

## Operation
- States: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE. All outputs registered.
- IDLE: START=1 → latch NUM_VECTORS (N) and go to CLEAR. START in any other state is ignored.
- CLEAR: 1 cycle, PE_CLR=1 → LOAD.
- LOAD: COLS cycles, W_RD_EN=1, W_RD_ADDR=0..COLS-1 → COMPUTE (N>0) or DONE (N=0).
- COMPUTE: N cycles, A_RD_EN=1, A_RD_ADDR=0..N-1 → DRAIN.
- DRAIN: ROWS+COLS-1 cycles, no reads → DONE.
- DONE: 1 cycle, DONE=1 → IDLE.
- Buffer read latency is 1 cycle. PE_EN is the 1-cycle-delayed OR of (LOAD|COMPUTE|DRAIN). PE_LOAD is delayed LOAD. ACT_ZERO is delayed DRAIN.
- OUT_WR_EN is high for exactly N cycles, starting ROWS cycles after the first compute-mode PE_EN cycle. OUT_WR_ADDR runs 0..N-1. External deskew aligns later columns.
- N=0: no COMPUTE, no DRAIN, no OUT_WR_EN. DONE still pulses.
- N > 2^ADDR_WIDTH is saturated to 2^ADDR_WIDTH.
- Address counters do not wrap within a job. All counters are cleared on entry to IDLE.

## Timing
- Reset: SYNC_RST=1 at an edge puts the block in IDLE and drives every output to 0 from the next cycle. This holds mid-job: no DONE is issued for an aborted job. SYNC_RST has priority over START.
- Cycle numbering: cycle 0 is the cycle in which START is sampled in IDLE.
- Cycle 1: CLEAR.
- Cycles 2..COLS+1: LOAD reads.
- Cycles 3..COLS+2: PE_EN=PE_LOAD=1.
- Cycles COLS+2..COLS+1+N: COMPUTE reads.
- Cycles COLS+2+N..2·COLS+ROWS+N: DRAIN.
- Cycle 2·COLS+ROWS+N+1: DONE.
- BUSY is high from cycle 1 through the DONE cycle inclusive.
- A new START is accepted in the cycle after DONE (back-to-back jobs). START coincident with DONE is ignored.

## Test plan
- ROWS=COLS=4, START with N=3 → PE_CLR @1; W_RD_ADDR 0..3 @2–5; PE_LOAD @3–6; A_RD_ADDR 0..2 @6–8; ACT_ZERO @10–16; OUT_WR_EN with addr 0..2 @11–13; DONE @16; BUSY @1–16.
- Same config, N=0 → LOAD @2–5, DONE @6, no A_RD_EN and no OUT_WR_EN.
- START pulsed during COMPUTE, and again coincident with DONE → both ignored; timing identical to the first scenario. A START at the cycle after DONE launches a second job whose PE_CLR appears one cycle later.
- SYNC_RST asserted at cycle 7 of an N=3 job → all outputs 0 from cycle 8, no DONE. A subsequent START runs a full job normally.
- N=300 with ADDR_WIDTH=8 → saturates to 256 reads (A_RD_ADDR 0..255 with no wrap); 256 OUT_WR_EN cycles.
- Integration with an 4x4 PE array, identity weights and activations 1..4 → output buffer contents after deskew equal the input vectors.
